// File: rtl/i2c_line_conditioner.sv
// i2c_line_conditioner
// Conditions raw SCL/SDA pad values for an I2C slave or monitor:
// two-flop synchronisers, per-line glitch filters, registered SCL edge
// strobes, START/STOP detection and a bus-state FSM with an SCL-low
// timeout. All logic runs on clk; rst_n is asynchronous, active-low.

module i2c_line_conditioner #(
  parameter int FILTER_CYCLES  = 3,        // 1..15
  parameter int TIMEOUT_CYCLES = 1250000   // >= 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_raw,
  input  logic sda_raw,
  output logic scl_f,
  output logic sda_f,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic bus_busy,
  output logic bus_timeout
);

  // Low-time counter width and its saturation value.
  localparam int              LW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [LW-1:0]   TO_MAX  = LW'(TIMEOUT_CYCLES);
  localparam logic [LW-1:0]   LOW_ONE = LW'(1);

  // Filter counter value at which the next differing cycle commits.
  localparam logic [3:0]      FC_LAST = 4'(FILTER_CYCLES - 1);

  // Bus FSM encoding.
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_BUSY    = 2'd1;
  localparam logic [1:0] ST_TIMEOUT = 2'd2;

  // Line index 0 is SCL, index 1 is SDA.
  logic [1:0] w_raw;
  logic [1:0] w_filt;        // current filtered value per line
  logic [1:0] w_filt_next;   // filtered value after the coming edge

  assign w_raw = {sda_raw, scl_raw};

  // ------------------------------------------------------------------
  // Per-line synchroniser and glitch filter.
  // ------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_line
      logic       r_sync1;
      logic       r_sync2;
      logic       r_filt;
      logic [3:0] r_fcnt;
      logic       w_line_filt_next;
      logic [3:0] w_line_fcnt_next;

      // Filter decision: count consecutive disagreeing cycles; commit the
      // synchronised value on the FILTER_CYCLES-th one, restart otherwise.
      always_comb begin
        w_line_filt_next = r_filt;
        w_line_fcnt_next = 4'd0;
        if (r_sync2 != r_filt) begin
          if (r_fcnt == FC_LAST) begin
            w_line_filt_next = r_sync2;
          end else begin
            w_line_fcnt_next = r_fcnt + 4'd1;
          end
        end
      end

      // Synchroniser, filter counter and filtered value; idle bus level is 1.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_sync1 <= 1'b1;
          r_sync2 <= 1'b1;
          r_filt  <= 1'b1;
          r_fcnt  <= 4'd0;
        end else begin
          r_sync1 <= w_raw[gi];
          r_sync2 <= r_sync1;
          r_filt  <= w_line_filt_next;
          r_fcnt  <= w_line_fcnt_next;
        end
      end

      assign w_filt[gi]      = r_filt;
      assign w_filt_next[gi] = w_line_filt_next;
    end
  endgenerate

  // ------------------------------------------------------------------
  // Edge and condition strobes. They are computed from the current and
  // next filtered values so that each strobe is high in the very first
  // cycle the filtered line shows its new level.
  // ------------------------------------------------------------------
  logic w_scl_cur;
  logic w_scl_nxt;
  logic w_sda_cur;
  logic w_sda_nxt;

  assign w_scl_cur = w_filt[0];
  assign w_scl_nxt = w_filt_next[0];
  assign w_sda_cur = w_filt[1];
  assign w_sda_nxt = w_filt_next[1];

  logic r_scl_rise;
  logic r_scl_fall;
  logic r_start_det;
  logic r_stop_det;

  // START/STOP need SCL steady high across the SDA edge, so a coincident
  // SCL change yields only the SCL strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scl_rise  <= 1'b0;
      r_scl_fall  <= 1'b0;
      r_start_det <= 1'b0;
      r_stop_det  <= 1'b0;
    end else begin
      r_scl_rise  <= ~w_scl_cur &  w_scl_nxt;
      r_scl_fall  <=  w_scl_cur & ~w_scl_nxt;
      r_start_det <=  w_scl_cur &  w_scl_nxt &  w_sda_cur & ~w_sda_nxt;
      r_stop_det  <=  w_scl_cur &  w_scl_nxt & ~w_sda_cur &  w_sda_nxt;
    end
  end

  // ------------------------------------------------------------------
  // Bus FSM with SCL-low timeout.
  // ------------------------------------------------------------------
  logic [1:0]    r_state;
  logic [1:0]    w_state_next;
  logic [LW-1:0] r_low_cnt;
  logic [LW-1:0] w_low_cnt_next;

  // Next-state and low-time counter. The counter only runs in BUSY and is
  // zeroed on every transition, so it starts fresh after each state change.
  always_comb begin
    w_state_next   = r_state;
    w_low_cnt_next = r_low_cnt;
    case (r_state)
      ST_IDLE: begin
        w_low_cnt_next = '0;
        if (r_start_det) begin
          w_state_next = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (r_stop_det) begin
          w_state_next   = ST_IDLE;
          w_low_cnt_next = '0;
        end else if (r_low_cnt == TO_MAX) begin
          w_state_next   = ST_TIMEOUT;
          w_low_cnt_next = '0;
        end else if (w_scl_cur) begin
          w_low_cnt_next = '0;
        end else begin
          w_low_cnt_next = r_low_cnt + LOW_ONE;
        end
      end
      ST_TIMEOUT: begin
        w_low_cnt_next = '0;
        if (r_stop_det) begin
          w_state_next = ST_IDLE;
        end else if (r_start_det) begin
          w_state_next = ST_BUSY;
        end
      end
      default: begin
        w_state_next   = ST_IDLE;
        w_low_cnt_next = '0;
      end
    endcase
  end

  // FSM state and low-time counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_low_cnt <= '0;
    end else begin
      r_state   <= w_state_next;
      r_low_cnt <= w_low_cnt_next;
    end
  end

  // ------------------------------------------------------------------
  // Outputs.
  // ------------------------------------------------------------------
  assign scl_f       = w_filt[0];
  assign sda_f       = w_filt[1];
  assign scl_rise    = r_scl_rise;
  assign scl_fall    = r_scl_fall;
  assign start_det   = r_start_det;
  assign stop_det    = r_stop_det;
  assign bus_busy    = (r_state != ST_IDLE);
  assign bus_timeout = (r_state == ST_TIMEOUT);

endmodule

// File: tb/tb_i2c_line_conditioner.sv
// Testbench for i2c_line_conditioner (FILTER_CYCLES=3, TIMEOUT_CYCLES=1000).
// Directed steps drive the raw lines; every strobe the bench expects is
// queued with its expected cycle and checked off when the DUT emits it.

module tb_i2c_line_conditioner;

  localparam int LAT = 5;   // 2 synchroniser flops + 3 filter cycles

  localparam int K_RISE  = 0;
  localparam int K_FALL  = 1;
  localparam int K_START = 2;
  localparam int K_STOP  = 3;

  logic clk;
  logic rst_n;
  logic scl_raw;
  logic sda_raw;
  logic scl_f;
  logic sda_f;
  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;
  logic bus_busy;
  logic bus_timeout;

  i2c_line_conditioner #(
    .FILTER_CYCLES (3),
    .TIMEOUT_CYCLES(1000)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .scl_raw    (scl_raw),
    .sda_raw    (sda_raw),
    .scl_f      (scl_f),
    .sda_f      (sda_f),
    .scl_rise   (scl_rise),
    .scl_fall   (scl_fall),
    .start_det  (start_det),
    .stop_det   (stop_det),
    .bus_busy   (bus_busy),
    .bus_timeout(bus_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  ev_t exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int n_rise  = 0;
  int n_fall  = 0;
  int n_start = 0;
  int n_stop  = 0;

  // Bench's own view of the filtered line levels once all drives settle.
  bit m_scl = 1'b1;
  bit m_sda = 1'b1;

  function automatic string kname(input int k);
    case (k)
      K_RISE:  return "scl_rise";
      K_FALL:  return "scl_fall";
      K_START: return "start_det";
      default: return "stop_det";
    endcase
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Match one observed strobe against the head of the expectation queue.
  task automatic take(input int k);
    ev_t e;
    if (exp_q.size() == 0) begin
      chk({"unexpected_", kname(k)}, cyc, -1);
    end else begin
      e = exp_q.pop_front();
      chk({"strobe_kind_", kname(k)}, k, e.kind);
      chk({"strobe_cycle_", kname(k)}, cyc, e.cyc);
      $display("[TB] cycle %0d: %s (expected %s at %0d)", cyc, kname(k), kname(e.kind), e.cyc);
    end
  endtask

  // Monitor: sample strobes half a cycle after the active edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (scl_rise  === 1'b1) begin n_rise++;  take(K_RISE);  end
      if (scl_fall  === 1'b1) begin n_fall++;  take(K_FALL);  end
      if (start_det === 1'b1) begin n_start++; take(K_START); end
      if (stop_det  === 1'b1) begin n_stop++;  take(K_STOP);  end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input int k);
    ev_t e;
    e.kind = k;
    e.cyc  = cyc + LAT;
    exp_q.push_back(e);
  endtask

  task automatic drive_scl(input bit v);
    if (v != m_scl) push(v ? K_RISE : K_FALL);
    scl_raw = v;
    m_scl   = v;
  endtask

  task automatic drive_sda(input bit v);
    if (v != m_sda && m_scl) push(v ? K_STOP : K_START);
    sda_raw = v;
    m_sda   = v;
  endtask

  // Both lines change together: only the SCL edge is a legal strobe.
  task automatic drive_both(input bit s, input bit d);
    if (s != m_scl) push(s ? K_RISE : K_FALL);
    scl_raw = s;
    sda_raw = d;
    m_scl   = s;
    m_sda   = d;
  endtask

  task automatic drained(input string tag);
    chk({tag, "_pending_events"}, exp_q.size(), 0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_scl_f"},       int'(scl_f),       1);
    chk({tag, "_sda_f"},       int'(sda_f),       1);
    chk({tag, "_scl_rise"},    int'(scl_rise),    0);
    chk({tag, "_scl_fall"},    int'(scl_fall),    0);
    chk({tag, "_start_det"},   int'(start_det),   0);
    chk({tag, "_stop_det"},    int'(stop_det),    0);
    chk({tag, "_bus_busy"},    int'(bus_busy),    0);
    chk({tag, "_bus_timeout"}, int'(bus_timeout), 0);
  endtask

  initial begin
    int  c0;
    int  t0;
    int  fell;
    bit  seen_low;
    int  r0, f0, s0, p0;

    rst_n   = 1'b0;
    scl_raw = 1'b1;
    sda_raw = 1'b1;

    // ---- Reset state ----
    wait_cyc(3);
    chk_reset_state("reset");
    rst_n = 1'b1;
    wait_cyc(10);
    chk("idle_bus_busy", int'(bus_busy), 0);

    // ---- Filter latency: START with SCL held high ----
    c0 = cyc;
    drive_sda(1'b0);
    fell = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sda_f === 1'b0) begin
        fell = cyc - c0;
        break;
      end
    end
    chk("sda_f_fall_latency", fell, LAT);
    chk("busy_in_start_cycle", int'(bus_busy), 0);
    @(negedge clk);
    chk("busy_after_start", int'(bus_busy), 1);
    wait_cyc(5);
    drive_sda(1'b1);
    wait_cyc(10);
    chk("busy_after_stop", int'(bus_busy), 0);
    drained("latency");

    // ---- Glitch rejection: 2-cycle pulse is dropped ----
    sda_raw = 1'b0;
    wait_cyc(2);
    sda_raw  = 1'b1;
    seen_low = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (sda_f !== 1'b1) seen_low = 1'b1;
    end
    chk("glitch2_sda_f_low_seen", int'(seen_low), 0);
    chk("glitch2_bus_busy", int'(bus_busy), 0);

    // ---- 3-cycle pulse passes: START then STOP ----
    drive_sda(1'b0);
    wait_cyc(3);
    drive_sda(1'b1);
    wait_cyc(12);
    chk("pulse3_bus_busy", int'(bus_busy), 0);
    drained("pulse3");

    // ---- Full byte: START, 9 SCL pulses, STOP ----
    r0 = n_rise; f0 = n_fall; s0 = n_start; p0 = n_stop;
    drive_sda(1'b0);
    wait_cyc(10);
    for (int b = 0; b < 9; b++) begin
      drive_scl(1'b0);
      wait_cyc(20);
      drive_scl(1'b1);
      wait_cyc(20);
    end
    chk("byte_busy_before_stop", int'(bus_busy), 1);
    drive_sda(1'b1);
    wait_cyc(10);
    chk("byte_rise_count",  n_rise  - r0, 9);
    chk("byte_fall_count",  n_fall  - f0, 9);
    chk("byte_start_count", n_start - s0, 1);
    chk("byte_stop_count",  n_stop  - p0, 1);
    chk("byte_busy_after_stop", int'(bus_busy), 0);
    drained("byte");

    // ---- Timeout: SCL held low for 1100 cycles after START ----
    drive_sda(1'b0);
    wait_cyc(10);
    t0 = cyc;
    drive_scl(1'b0);
    while (bus_timeout !== 1'b1 && (cyc - t0) < 1200) @(negedge clk);
    // scl_f falls LAT cycles after the drive; TIMEOUT follows 1001 cycles later.
    chk("timeout_onset_cycle", cyc - t0, LAT + 1001);
    while ((cyc - t0) < 1100) @(negedge clk);
    chk("timeout_held_flag", int'(bus_timeout), 1);
    chk("timeout_held_busy", int'(bus_busy), 1);
    drive_scl(1'b1);
    wait_cyc(10);
    chk("timeout_after_scl_high", int'(bus_timeout), 1);
    drive_sda(1'b1);
    wait_cyc(10);
    chk("timeout_stop_busy", int'(bus_busy), 0);
    chk("timeout_stop_flag", int'(bus_timeout), 0);
    drained("timeout");

    // ---- Simultaneous SCL/SDA edges ----
    drive_both(1'b0, 1'b0);
    wait_cyc(10);
    chk("simul_fall_busy", int'(bus_busy), 0);
    drive_both(1'b1, 1'b1);
    wait_cyc(10);
    chk("simul_rise_busy", int'(bus_busy), 0);
    drained("simultaneous");

    // ---- Repeated START keeps the bus busy ----
    drive_sda(1'b0);
    wait_cyc(10);
    drive_scl(1'b0);
    wait_cyc(10);
    drive_sda(1'b1);
    wait_cyc(10);
    drive_scl(1'b1);
    wait_cyc(10);
    s0 = n_start;
    drive_sda(1'b0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("rstart_busy_held", int'(bus_busy), 1);
    end
    chk("rstart_start_count", n_start - s0, 1);
    drive_sda(1'b1);
    wait_cyc(10);
    chk("rstart_stop_busy", int'(bus_busy), 0);
    drained("repeated_start");

    // ---- Reset while BUSY with SCL low ----
    drive_sda(1'b0);
    wait_cyc(10);
    drive_scl(1'b0);
    wait_cyc(10);
    chk("pre_reset_busy", int'(bus_busy), 1);
    drained("pre_reset");
    rst_n = 1'b0;
    #1;
    chk_reset_state("midreset");
    wait_cyc(3);
    m_scl = 1'b1;
    m_sda = 1'b1;
    rst_n = 1'b1;
    drive_both(1'b0, 1'b0);   // lines are still low; filter catches up
    wait_cyc(10);
    chk("post_reset_busy", int'(bus_busy), 0);
    drive_scl(1'b1);
    wait_cyc(10);
    drive_scl(1'b0);
    wait_cyc(10);
    drive_scl(1'b1);
    wait_cyc(10);
    chk("post_reset_scl_activity_busy", int'(bus_busy), 0);
    drive_sda(1'b1);          // STOP-shaped edge while IDLE
    wait_cyc(10);
    chk("post_reset_stop_busy", int'(bus_busy), 0);
    drive_sda(1'b0);          // new START
    wait_cyc(10);
    chk("post_reset_start_busy", int'(bus_busy), 1);
    drive_sda(1'b1);
    wait_cyc(10);
    chk("final_busy", int'(bus_busy), 0);
    drained("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
